// File: rtl/xadc_drp_responder.sv
// xadc_drp_responder: behavioural stand-in for the XADC DRP port and a
// two-channel (VAUX0/VAUX1) conversion sequencer. Test samples are captured
// left-justified on a fixed cadence, and DRP reads/writes are answered with a
// one-cycle drdy pulse after a fixed latency.
module xadc_drp_responder #(
    parameter int         CONV_CYCLES = 26,
    parameter int         DRP_LATENCY = 4,
    parameter logic [6:0] CH0_ADDR    = 7'h10,
    parameter logic [6:0] CH1_ADDR    = 7'h11,
    parameter logic [6:0] CFG_ADDR    = 7'h41
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic [11:0] sample_a0,
    input  logic [11:0] sample_a1,
    input  logic        den_in,
    input  logic [6:0]  daddr_in,
    input  logic        dwe_in,
    input  logic [15:0] di_in,
    output logic [15:0] do_out,
    output logic        drdy_out,
    output logic        eoc_out,
    output logic        eos_out,
    output logic [4:0]  channel_out,
    output logic        busy_out,
    output logic        proto_err_out
);

    localparam int            CW       = $clog2(CONV_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(CONV_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [3:0]    LAT_LOAD = 4'(DRP_LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } drp_state_t;

    // Sequencer state
    logic [CW-1:0] cnt_r;
    logic          cur_r;          // 0 = CH0 (switch), 1 = CH1 (feed)
    logic [15:0]   result0_r;
    logic [15:0]   result1_r;
    logic [15:0]   cfg_r;
    logic          eoc_r;
    logic          eos_r;
    logic [4:0]    channel_r;
    logic          busy_r;

    // DRP state
    drp_state_t    state_r;
    drp_state_t    state_s;
    logic [3:0]    lat_r;
    logic [6:0]    addr_r;
    logic          we_r;
    logic [15:0]   di_r;
    logic [15:0]   do_r;
    logic          drdy_r;
    logic          perr_r;

    // Response-edge controls (comb)
    logic          resp_go_s;
    logic [6:0]    req_addr_s;
    logic          req_we_s;
    logic [15:0]   req_di_s;
    logic [15:0]   rd_data_s;

    // Conversion cadence: count, capture sample, pulse eoc/eos, toggle channel
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt_r     <= '0;
            cur_r     <= 1'b0;
            result0_r <= 16'h0000;
            result1_r <= 16'h0000;
            eoc_r     <= 1'b0;
            eos_r     <= 1'b0;
            channel_r <= 5'h00;
            busy_r    <= 1'b0;
        end else begin
            // busy drops while paused and for the cycle right after an eoc
            busy_r <= ~cfg_r[0] & ~eoc_r;
            if (cfg_r[0]) begin
                eoc_r <= 1'b0;
                eos_r <= 1'b0;
            end else if (cnt_r == CNT_LAST) begin
                cnt_r     <= '0;
                cur_r     <= ~cur_r;
                eoc_r     <= 1'b1;
                eos_r     <= cur_r;
                channel_r <= cur_r ? CH1_ADDR[4:0] : CH0_ADDR[4:0];
                if (cur_r) begin
                    result1_r <= {sample_a1, 4'b0000};
                end else begin
                    result0_r <= {sample_a0, 4'b0000};
                end
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
                eoc_r <= 1'b0;
                eos_r <= 1'b0;
            end
        end
    end

    // DRP FSM state register
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // DRP FSM next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (den_in) begin
                    state_s = (DRP_LATENCY == 1) ? ST_RESP : ST_WAIT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (lat_r <= 4'd1) begin
                    state_s = ST_RESP;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_RESP: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // DRP FSM outputs: response strobe and read-data selection
    always_comb begin
        resp_go_s = (state_s == ST_RESP);
        // single-cycle latency responds straight from the incoming request
        if (state_r == ST_IDLE) begin
            req_addr_s = daddr_in;
            req_we_s   = dwe_in;
            req_di_s   = di_in;
        end else begin
            req_addr_s = addr_r;
            req_we_s   = we_r;
            req_di_s   = di_r;
        end
        if (req_addr_s == CH0_ADDR) begin
            rd_data_s = result0_r;
        end else if (req_addr_s == CH1_ADDR) begin
            rd_data_s = result1_r;
        end else if (req_addr_s == CFG_ADDR) begin
            rd_data_s = cfg_r;
        end else begin
            rd_data_s = 16'h0000;
        end
    end

    // Request capture and latency countdown
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            lat_r  <= 4'd0;
            addr_r <= 7'h00;
            we_r   <= 1'b0;
            di_r   <= 16'h0000;
        end else if ((state_r == ST_IDLE) && den_in) begin
            lat_r  <= LAT_LOAD;
            addr_r <= daddr_in;
            we_r   <= dwe_in;
            di_r   <= di_in;
        end else if (state_r == ST_WAIT) begin
            lat_r <= lat_r - 4'd1;
        end else begin
            lat_r <= lat_r;
        end
    end

    // Response edge: drdy, read data, config write, sticky protocol error
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            drdy_r <= 1'b0;
            do_r   <= 16'h0000;
            cfg_r  <= 16'h0000;
            perr_r <= 1'b0;
        end else begin
            drdy_r <= resp_go_s;
            if (resp_go_s && !req_we_s) begin
                do_r <= rd_data_s;
            end else if (resp_go_s && (req_addr_s == CFG_ADDR)) begin
                cfg_r <= req_di_s;
            end else begin
                do_r <= do_r;
            end
            if (den_in && (state_r != ST_IDLE)) begin
                perr_r <= 1'b1;
            end else begin
                perr_r <= perr_r;
            end
        end
    end

    assign do_out        = do_r;
    assign drdy_out      = drdy_r;
    assign eoc_out       = eoc_r;
    assign eos_out       = eos_r;
    assign channel_out   = channel_r;
    assign busy_out      = busy_r;
    assign proto_err_out = perr_r;

endmodule

// File: tb/tb_xadc_drp_responder.sv
// Scoreboard bench for xadc_drp_responder: stimulus pushes expected DRP
// responses and eoc events into queues; a negedge monitor pops and compares.
module tb_xadc_drp_responder;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        clr_n;
    logic [11:0] sample_a0;
    logic [11:0] sample_a1;
    logic        den_in;
    logic [6:0]  daddr_in;
    logic        dwe_in;
    logic [15:0] di_in;
    logic [15:0] do_out;
    logic        drdy_out;
    logic        eoc_out;
    logic        eos_out;
    logic [4:0]  channel_out;
    logic        busy_out;
    logic        proto_err_out;

    xadc_drp_responder dut (
        .clk           (clk),
        .clr_n         (clr_n),
        .sample_a0     (sample_a0),
        .sample_a1     (sample_a1),
        .den_in        (den_in),
        .daddr_in      (daddr_in),
        .dwe_in        (dwe_in),
        .di_in         (di_in),
        .do_out        (do_out),
        .drdy_out      (drdy_out),
        .eoc_out       (eoc_out),
        .eos_out       (eos_out),
        .channel_out   (channel_out),
        .busy_out      (busy_out),
        .proto_err_out (proto_err_out)
    );

    always #5 clk = ~clk;

    // cycle index = number of rising edges since reset release
    int cyc;
    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct { int cyc; logic [15:0] data; } drp_exp_t;
    typedef struct { int cyc; logic [4:0] ch; logic eos; } eoc_exp_t;
    drp_exp_t drp_q[$];
    eoc_exp_t eoc_q[$];
    drp_exp_t de;
    eoc_exp_t ee;
    logic        eoc_watch = 1'b0;
    logic [15:0] last_do   = 16'h0000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare every DUT response against the head of its queue
    always @(negedge clk) begin
        if (clr_n) begin
            if (drdy_out) begin
                if (drp_q.size() == 0) begin
                    check("unexpected_drdy", {31'd0, drdy_out}, 32'd0);
                end else begin
                    de = drp_q.pop_front();
                    check("drdy_cycle", cyc, de.cyc);
                    check("do_out", {16'd0, do_out}, {16'd0, de.data});
                end
            end
            if (eoc_watch && eoc_out) begin
                if (eoc_q.size() == 0) begin
                    check("unexpected_eoc", {31'd0, eoc_out}, 32'd0);
                end else begin
                    ee = eoc_q.pop_front();
                    check("eoc_cycle", cyc, ee.cyc);
                    check("channel_out", {27'd0, channel_out}, {27'd0, ee.ch});
                    check("eos_out", {31'd0, eos_out}, {31'd0, ee.eos});
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) step(1);
    endtask

    task automatic pulse_den(input logic [6:0] a, input logic we, input logic [15:0] d);
        den_in = 1'b1; daddr_in = a; dwe_in = we; di_in = d;
        step(1);
        den_in = 1'b0; dwe_in = 1'b0;
    endtask

    task automatic push_drp(input int c, input logic [15:0] d);
        drp_exp_t e;
        e.cyc = c; e.data = d;
        drp_q.push_back(e);
    endtask

    task automatic push_eoc(input int c, input logic [4:0] ch, input logic eos);
        eoc_exp_t e;
        e.cyc = c; e.ch = ch; e.eos = eos;
        eoc_q.push_back(e);
    endtask

    // read: den in this cycle, drdy LAT cycles later; returns ready for next den
    task automatic drp_read(input logic [6:0] a, input logic [15:0] exp);
        push_drp(cyc + LAT, exp);
        last_do = exp;
        pulse_den(a, 1'b0, 16'h0000);
        step(LAT);
    endtask

    task automatic drp_write(input logic [6:0] a, input logic [15:0] d);
        push_drp(cyc + LAT, last_do);
        pulse_den(a, 1'b1, d);
        step(LAT);
    endtask

    int tA, tB, m, e0, c0;
    logic found;

    initial begin
        clr_n = 1'b0; den_in = 1'b0; daddr_in = 7'h00; dwe_in = 1'b0; di_in = 16'h0000;
        sample_a0 = 12'hABC; sample_a1 = 12'h123;
        #12;
        check("reset_outputs", {6'd0, do_out, drdy_out, eoc_out, eos_out, channel_out, busy_out, proto_err_out}, 32'd0);

        // 1: first two conversions after reset release
        push_eoc(26, 5'h10, 1'b0);
        push_eoc(52, 5'h11, 1'b1);
        eoc_watch = 1'b1;
        #6 clr_n = 1'b1;
        step(1);
        wait_until(5);  check("busy_counting", {31'd0, busy_out}, 32'd1);
        wait_until(27); check("busy_low_27", {31'd0, busy_out}, 32'd0);
        step(1);        check("busy_back_28", {31'd0, busy_out}, 32'd1);
        wait_until(53); check("busy_low_53", {31'd0, busy_out}, 32'd0);
        wait_until(56);
        eoc_watch = 1'b0;
        check("eoc_q_empty_t1", eoc_q.size(), 32'd0);

        // 2: reads of both results and an unmapped address
        wait_until(61);
        drp_read(7'h10, 16'hABC0);
        drp_read(7'h11, 16'h1230);
        drp_read(7'h05, 16'h0000);

        // 3: pause via config, read it back, resume with remaining count
        while ((cyc % 26) != 5) step(1);
        tA = cyc + LAT;
        drp_write(7'h41, 16'h0001);
        eoc_watch = 1'b1;
        step(1);
        check("busy_paused", {31'd0, busy_out}, 32'd0);
        step(30);
        drp_read(7'h41, 16'h0001);
        step(5);
        tB = cyc + LAT;
        drp_write(7'h41, 16'h0000);
        m = 26 * (tA / 26 + 1);
        if (((m / 26) % 2) == 1) push_eoc(m + tB - tA, 5'h10, 1'b0);
        else                     push_eoc(m + tB - tA, 5'h11, 1'b1);
        wait_until(m + tB - tA + 2);
        eoc_watch = 1'b0;
        check("eoc_q_empty_t3", eoc_q.size(), 32'd0);

        // 4: read lands on a CH0 eoc edge -> pre-update value
        sample_a0 = 12'h111;
        found = 1'b0;
        for (int i = 0; i < 80 && !found; i++) begin
            step(1);
            if (eoc_out && (channel_out == 5'h10)) found = 1'b1;
        end
        check("ch0_eoc_seen", {31'd0, found}, 32'd1);
        e0 = cyc;
        step(1);
        sample_a0 = 12'h222;
        wait_until(e0 + 52 - LAT);
        drp_read(7'h10, 16'h1110);
        drp_read(7'h10, 16'h2220);

        // 5: back-to-back accepted cleanly, then overlapping den flagged
        drp_read(7'h05, 16'h0000);
        drp_read(7'h41, 16'h0000);
        check("no_err_b2b", {31'd0, proto_err_out}, 32'd0);
        c0 = cyc;
        push_drp(c0 + LAT, 16'h1230);
        last_do = 16'h1230;
        pulse_den(7'h11, 1'b0, 16'h0000);
        step(1);
        pulse_den(7'h41, 1'b1, 16'hFFFF);
        check("proto_err_set", {31'd0, proto_err_out}, 32'd1);
        step(6);
        check("proto_err_sticky", {31'd0, proto_err_out}, 32'd1);
        drp_read(7'h41, 16'h0000);

        // 6: reset mid-transaction drops it and clears everything
        pulse_den(7'h10, 1'b0, 16'h0000);
        step(1);
        #2 clr_n = 1'b0;
        #1;
        check("reset_mid_outputs", {6'd0, do_out, drdy_out, eoc_out, eos_out, channel_out, busy_out, proto_err_out}, 32'd0);
        check("drp_q_empty_t6", drp_q.size(), 32'd0);
        last_do = 16'h0000;
        push_eoc(26, 5'h10, 1'b0);
        eoc_watch = 1'b1;
        #4 clr_n = 1'b1;
        step(1);
        wait_until(3);
        drp_read(7'h11, 16'h0000);
        drp_read(7'h10, 16'h0000);
        drp_read(7'h41, 16'h0000);
        wait_until(28);
        eoc_watch = 1'b0;
        check("eoc_q_empty_t6", eoc_q.size(), 32'd0);
        drp_read(7'h10, 16'h2220);
        step(3);
        check("drp_q_empty_end", drp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
